// File: rtl/bridge_reg_leaf.sv
// Register leaf on the bridge tree: four control registers, four sampled status
// words, a single-entry command mailbox to the core, and a constant ID word.
module bridge_reg_leaf #(
    parameter logic [31:0] BASE_ADDR = 32'hF800_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
    parameter logic [31:0] LEAF_ID   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       bridge_addr,
    input  logic [31:0]       bridge_wr_data,
    input  logic              bridge_wr,
    input  logic              bridge_rd,
    output logic [31:0]       bridge_rd_data,
    output logic [3:0][31:0]  ctrl_out,
    output logic [3:0]        ctrl_wr_pulse,
    input  logic [3:0][31:0]  stat_in,
    output logic              cmd_valid,
    output logic [31:0]       cmd_data,
    input  logic              cmd_ready
);

    localparam logic [5:0] OFF_CMD     = 6'h08;
    localparam logic [5:0] OFF_CMD_STS = 6'h09;
    localparam logic [5:0] OFF_LEAF_ID = 6'h0A;

    logic        sel;
    logic [5:0]  off;
    logic        wr_hit;
    logic        ctrl_wr;
    logic        cmd_wr;
    logic        cmd_take;
    logic        ovf_set;
    logic        ovf_clr;
    logic        overflow;
    logic [31:0] rd_value;

    assign sel      = (bridge_addr & ADDR_MASK) == BASE_ADDR;
    assign off      = bridge_addr[7:2];
    assign wr_hit   = bridge_wr && sel;
    assign ctrl_wr  = wr_hit && (off[5:2] == 4'h0);
    assign cmd_wr   = wr_hit && (off == OFF_CMD);
    // A CMD write is taken when the mailbox is empty or being drained this cycle.
    assign cmd_take = cmd_wr && (!cmd_valid || cmd_ready);
    assign ovf_set  = cmd_wr && cmd_valid && !cmd_ready;
    assign ovf_clr  = wr_hit && (off == OFF_CMD_STS) && bridge_wr_data[1];

    always_comb begin
        rd_value = '0;
        case (off)
            6'h00, 6'h01, 6'h02, 6'h03: rd_value = ctrl_out[off[1:0]];
            6'h04, 6'h05, 6'h06, 6'h07: rd_value = stat_in[off[1:0]];
            OFF_CMD:                    rd_value = cmd_data;
            OFF_CMD_STS:                rd_value = {30'd0, overflow, cmd_valid};
            OFF_LEAF_ID:                rd_value = LEAF_ID;
            default:                    rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bridge_rd_data <= '0;
        end else if (bridge_rd) begin
            bridge_rd_data <= sel ? rd_value : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_out      <= '0;
            ctrl_wr_pulse <= '0;
        end else begin
            ctrl_wr_pulse <= '0;
            if (ctrl_wr) begin
                ctrl_out[off[1:0]]      <= bridge_wr_data;
                ctrl_wr_pulse[off[1:0]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
        end else if (cmd_take) begin
            cmd_valid <= 1'b1;
            cmd_data  <= bridge_wr_data;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // Set wins over clear so a coinciding overflow is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
